// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;

    // PS/2 uses odd parity over the data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// CPU-side i/o bus view of the PS/2 scan-code buffer.
interface ps2_key_rx_if;
    logic       io_rdn;
    logic [7:0] key_data;
    logic       ready;
    logic       overflow;

    modport master (output io_rdn, input key_data, ready, overflow);
    modport slave  (input io_rdn, output key_data, ready, overflow);
endinterface

// File: rtl/ps2_key_fifo.sv
// Synchronous scan-code FIFO; a push into a full FIFO is accepted only alongside a pop.
module ps2_key_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver feeding a scan-code FIFO read over the i/o bus.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_key_rx_if.slave  bus
);
    localparam int            TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2, fall;
    ps2_state_e state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [PS2_DATA_BITS-1:0] shreg, shreg_n;
    logic [TO_W-1:0] to_cnt, to_n;
    logic push_q, push_n;
    logic rdn_q, pop, drop, empty, full;
    logic [7:0] head;
    logic overflow;
`ifdef PS2_PARITY_CHECK_EN
    logic par, par_n;
`endif

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            state    <= IDLE;
            bitcnt   <= '0;
            shreg    <= '0;
            to_cnt   <= '0;
            push_q   <= 1'b0;
            rdn_q    <= 1'b1;
            overflow <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par      <= 1'b0;
`endif
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
            state    <= state_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            to_cnt   <= to_n;
            push_q   <= push_n;
            rdn_q    <= bus.io_rdn;
            overflow <= overflow | drop;
`ifdef PS2_PARITY_CHECK_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        to_n     = to_cnt;
        push_n   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_n    = par;
`endif
        if (!fall) begin
            // Stalled partial frame: abandon it so the next start bit resyncs.
            if (state != IDLE) begin
                if (to_cnt == TO_LAST) begin
                    state_n = IDLE;
                    to_n    = '0;
                end else begin
                    to_n = to_cnt + TO_W'(1);
                end
            end
        end else begin
            to_n = '0;
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n = {dat_s2, shreg[PS2_DATA_BITS-1:1]};
                    if (bitcnt == 3'd7) state_n = PARITY;
                    else                bitcnt_n = bitcnt + 3'd1;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_n = dat_s2;
`endif
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    push_n = dat_s2 & parity_ok(shreg, par);
`else
                    push_n = dat_s2;
`endif
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // shreg is stable for many cycles after STOP, so it feeds the FIFO directly.
    assign pop = ~rdn_q & bus.io_rdn & ~empty;

    ps2_key_fifo #(.AW(FIFO_AW), .W(PS2_DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (shreg),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .drop  (drop)
    );

    assign bus.key_data = head;
    assign bus.ready    = ~empty;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed scoreboard bench for ps2_key_rx with a shortened PS/2 bit time and timeout.
module tb_ps2_key_rx;
    import ps2_pkg::*;

    localparam int H  = 20;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_key_rx_if bus ();

    ps2_key_rx #(.FIFO_AW(3), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    logic ovf_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        sb.delete();
        ovf_exp = 1'b0;
    endtask

    // lat: check ready timing after the stop-bit fall; rd: complete a read so its pop lands with this push.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input bit lat, input bit rd);
        logic [7:0] rexp;
        bit ok;
        rexp = 8'h00;
        if (rd && sb.size() > 0) rexp = sb.pop_front();
        ok = stp;
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && (^{d, par});
`endif
        if (ok) begin
            if (sb.size() < 8) sb.push_back(d);
            else               ovf_exp = 1'b1;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_data = stp;
        if (rd) bus.io_rdn = 1'b0;
        tick(H);
        ps2_clk = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (lat) chk("latency", bus.ready, (i == 4));
            if (rd && i == 3) begin
                chk("rd_at_push", bus.key_data, rexp);
                bus.io_rdn = 1'b1;
            end
        end
        tick(H - 4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(H);
    endtask

    task automatic do_read(input int low);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        bus.io_rdn = 1'b0;
        tick(1);
        chk("rd_head", bus.key_data, e);
        tick(low - 1);
        chk("rd_hold", bus.key_data, e);
        bus.io_rdn = 1'b1;
        tick(1);
        chk("rd_ready", bus.ready, (sb.size() != 0));
        chk("rd_next", bus.key_data, (sb.size() != 0) ? sb[0] : 8'h00);
        chk("rd_ovf", bus.overflow, ovf_exp);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        bus.io_rdn = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_key", bus.key_data, 8'h00);
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);

        // single frame with latency check, then a 3-cycle read
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("single_key", bus.key_data, 8'h1C);
        do_read(3);

        // break code then make code, long reads pop once each
        send_frame(KEY_BREAK, good_par(KEY_BREAK), 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, good_par(8'h1C), 1'b1, 1'b0, 1'b0);
        do_read(5);
        do_read(5);

        // nine frames into depth 8
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), good_par(8'(i)), 1'b1, 1'b0, 1'b0);
        chk("ovf_set", bus.overflow, 1'b1);
        for (int i = 0; i < 8; i++) do_read(2);
        chk("ovf_drained_ready", bus.ready, 1'b0);

        do_reset();
        chk("ovf_cleared", bus.overflow, 1'b0);

        // full FIFO: push and pop land on the same edge
        for (int i = 1; i <= 8; i++)
            send_frame(8'(i), good_par(8'(i)), 1'b1, 1'b0, 1'b0);
        send_frame(8'h0A, good_par(8'h0A), 1'b1, 1'b0, 1'b1);
        chk("full_cnt", dut.u_fifo.count, 8);
        chk("full_ovf", bus.overflow, 1'b0);
        for (int i = 0; i < 8; i++) do_read(2);

        // stalled partial frame times out, next frame is clean
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        tick(TO + 50);
        chk("to_empty", bus.ready, 1'b0);
        send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b0, 1'b0);
        do_read(2);

        // bad stop bit discards the frame
        send_frame(8'h33, good_par(8'h33), 1'b0, 1'b0, 1'b0);
        tick(5);
        chk("stop0_ready", bus.ready, 1'b0);

        // wrong parity: rejected only when checking is built in
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_ready", bus.ready, (sb.size() != 0));
        do_read(2);

        // reset mid-frame discards the partial frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        do_reset();
        send_frame(8'h2B, good_par(8'h2B), 1'b1, 1'b0, 1'b0);
        do_read(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
